// File: rtl/riscv_pkg.sv
// Shared RV32I load/store encodings, LSU state encoding and access-legality helpers.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package riscv_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT_RSP,
        LSU_DONE
    } lsu_state_t;

    function automatic logic op_legal(input logic write, input logic [2:0] funct3);
        if (write)
            return (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
        return (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
               (funct3 == LBU) || (funct3 == LHU);
    endfunction

    // funct3[1:0] encodes the access size for every legal code.
    function automatic logic op_aligned(input logic [2:0] funct3, input logic [1:0] byte_off);
        case (funct3[1:0])
            2'b01:   return ~byte_off[0];
            2'b10:   return byte_off == 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane select / sign extension for loads.
// Latency: combinational.
// Backpressure: none.
module lsu_align
    import riscv_pkg::*;
(
    input  logic        write,
    input  logic [2:0]  funct3,
    input  logic [1:0]  byte_off,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata_fmt
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[8*byte_off +: 8];
    assign half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        be        = 4'b0000;
        wdata     = 32'h0;
        rdata_fmt = 32'h0;

        case (funct3[1:0])
            2'b00:   be = 4'b0001 << byte_off;
            2'b01:   be = 4'b0011 << {byte_off[1], 1'b0};
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase

        if (write) begin
            case (funct3)
                SB:      wdata = {4{store_data[7:0]}};
                SH:      wdata = {2{store_data[15:0]}};
                SW:      wdata = store_data;
                default: wdata = 32'h0;
            endcase
        end else begin
            case (funct3)
                LB:      rdata_fmt = {{24{byte_sel[7]}}, byte_sel};
                LH:      rdata_fmt = {{16{half_sel[15]}}, half_sel};
                LW:      rdata_fmt = rdata;
                LBU:     rdata_fmt = {24'h0, byte_sel};
                LHU:     rdata_fmt = {16'h0, half_sel};
                default: rdata_fmt = 32'h0;
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one memory operation at a time over a req/gnt + rvalid bus.
// Latency: 3 cycles accept-to-done minimum; 1 cycle for rejected (illegal/misaligned) ops.
// Backpressure: holds the request until mem_gnt; lsu_busy stalls the core until done.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lsu_valid,
    input  logic        lsu_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic        lsu_err,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_t  state;
    logic [CW-1:0] cnt;
    logic        op_write;
    logic [2:0]  op_f3;
    logic [1:0]  op_off;
    logic        timeout;

    logic        al_write;
    logic [2:0]  al_f3;
    logic [1:0]  al_off;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_fmt;

    // One aligner serves both phases: live inputs at accept, latched op afterwards.
    assign al_write = (state == LSU_IDLE) ? lsu_write  : op_write;
    assign al_f3    = (state == LSU_IDLE) ? funct3     : op_f3;
    assign al_off   = (state == LSU_IDLE) ? addr[1:0]  : op_off;

    lsu_align u_align (
        .write      (al_write),
        .funct3     (al_f3),
        .byte_off   (al_off),
        .store_data (store_data),
        .rdata      (mem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .rdata_fmt  (al_fmt)
    );

    assign timeout  = (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign lsu_busy = (state != LSU_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= LSU_IDLE;
            cnt       <= '0;
            op_write  <= 1'b0;
            op_f3     <= 3'b000;
            op_off    <= 2'b00;
            lsu_done  <= 1'b0;
            lsu_err   <= 1'b0;
            load_data <= 32'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'h0;
        end else begin
            lsu_done <= 1'b0;
            lsu_err  <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (lsu_valid) begin
                        op_write <= lsu_write;
                        op_f3    <= funct3;
                        op_off   <= addr[1:0];
                        if (op_legal(lsu_write, funct3) && op_aligned(funct3, addr[1:0])) begin
                            state     <= LSU_REQ;
                            cnt       <= '0;
                            mem_req   <= 1'b1;
                            mem_we    <= lsu_write;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= al_be;
                            mem_wdata <= al_wdata;
                        end else begin
                            state     <= LSU_DONE;
                            lsu_done  <= 1'b1;
                            lsu_err   <= 1'b1;
                            load_data <= 32'h0;
                        end
                    end
                end
                LSU_REQ: begin
                    cnt <= cnt + CW'(1);
                    if (timeout || mem_gnt) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= 32'h0;
                        mem_be    <= 4'b0000;
                        mem_wdata <= 32'h0;
                    end
                    // A grant on the final allowed cycle still times out.
                    if (timeout) begin
                        state     <= LSU_DONE;
                        lsu_done  <= 1'b1;
                        lsu_err   <= 1'b1;
                        load_data <= 32'h0;
                    end else if (mem_gnt) begin
                        state <= LSU_WAIT_RSP;
                    end
                end
                LSU_WAIT_RSP: begin
                    cnt <= cnt + CW'(1);
                    if (mem_rvalid) begin
                        state     <= LSU_DONE;
                        lsu_done  <= 1'b1;
                        load_data <= op_write ? 32'h0 : al_fmt;
                    end else if (timeout) begin
                        state     <= LSU_DONE;
                        lsu_done  <= 1'b1;
                        lsu_err   <= 1'b1;
                        load_data <= 32'h0;
                    end
                end
                default: begin
                    state <= LSU_IDLE;
                end
            endcase
        end
    end

endmodule
